// File: rtl/pwm_level_ramp.sv
// PWM upstream driver: prescaled count-advance strobe, PWM phase shadow and a
// duty level that is applied directly, slewed, or swept as a triangle.
//
// Ramp direction (breathe sweep):
// state | meaning
// UP    | level rising toward target (forced whenever mode is not breathe)
// DOWN  | level falling toward 0
module pwm_level_ramp #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     target,
  input  logic [WIDTH-1:0]     step,
  output logic                 strobe,
  output logic [WIDTH-1:0]     level,
  output logic                 period_end,
  output logic                 busy
);

  localparam logic [1:0] MODE_DIRECT  = 2'd0;
  localparam logic [1:0] MODE_SLEW    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [DIV_WIDTH-1:0] pre;
  logic [WIDTH-1:0]     phase;
  logic [WIDTH-1:0]     phase_next;
  logic                 pre_hit;
  logic                 boundary;
  dir_t                 dir;
  dir_t                 dir_next;
  logic [WIDTH-1:0]     level_next;
  logic [WIDTH:0]       level_plus;
  logic [WIDTH:0]       target_plus;

  assign pre_hit    = (pre == divider);
  assign phase_next = strobe ? phase + 1'b1 : phase;
  // period_end already encodes "strobe=1 and phase==all-ones" for this cycle
  assign boundary   = enable && period_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre        <= '0;
      phase      <= '0;
      strobe     <= 1'b0;
      period_end <= 1'b0;
    end else if (!enable) begin
      pre        <= '0;
      phase      <= '0;
      strobe     <= 1'b0;
      period_end <= 1'b0;
    end else begin
      pre        <= pre_hit ? '0 : pre + 1'b1;
      strobe     <= pre_hit;
      phase      <= phase_next;
      period_end <= pre_hit && (phase_next == '1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir   <= UP;
      level <= '0;
    end else begin
      dir   <= dir_next;
      level <= level_next;
    end
  end

  // One extra bit keeps level+step and target+step from wrapping.
  assign level_plus  = {1'b0, level} + {1'b0, step};
  assign target_plus = {1'b0, target} + {1'b0, step};

  always_comb begin
    dir_next   = dir;
    level_next = level;
    if (mode != MODE_BREATHE) dir_next = UP;
    if (boundary) begin
      case (mode)
        MODE_DIRECT: level_next = target;
        MODE_SLEW: begin
          if (level < target)
            level_next = (level_plus >= {1'b0, target}) ? target : level_plus[WIDTH-1:0];
          else if (level > target)
            level_next = ({1'b0, level} <= target_plus) ? target : level - step;
        end
        MODE_BREATHE: begin
          if (dir == UP) begin
            if (level_plus >= {1'b0, target}) begin
              level_next = target;
              dir_next   = DOWN;
            end else begin
              level_next = level_plus[WIDTH-1:0];
            end
          end else begin
            if (level <= step) begin
              level_next = '0;
              dir_next   = UP;
            end else begin
              level_next = level - step;
            end
          end
        end
        default: level_next = level;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    if ((mode == MODE_DIRECT) || (mode == MODE_SLEW)) busy = (level != target);
  end

endmodule

// File: tb/tb_pwm_level_ramp.sv
// Directed bench for pwm_level_ramp: strobe/period timing, slew, breathe,
// async reset and enable freeze, with expected levels queued per boundary.
module tb_pwm_level_ramp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] divider = 8'd3;
  logic [1:0] mode = 2'd3;
  logic [7:0] target = 8'd0;
  logic [7:0] step = 8'd0;
  logic       strobe;
  logic [7:0] level;
  logic       period_end;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  pwm_level_ramp #(.WIDTH(8), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .divider(divider),
    .mode(mode), .target(target), .step(step),
    .strobe(strobe), .level(level), .period_end(period_end), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input logic sel_pe, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel_pe ? period_end : strobe) && n < limit);
  endtask

  // Waits for the next period_end, then checks level after the boundary edge.
  task automatic boundary(input string tag);
    int n;
    logic [7:0] e;
    wait_for(1'b1, 3000, n);
    check({tag, "_pe"}, period_end, 1);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, level, e);
  endtask

  initial begin
    int n;
    int cnt;
    logic seen;

    #3 mode = 2'd1; target = 8'd200;
    #10;
    check("rst_strobe", strobe, 0);
    check("rst_period_end", period_end, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 1);
    mode = 2'd3;
    @(negedge clk) rst_n = 1'b1;

    // strobe timing at divider=3
    @(negedge clk) enable = 1'b1;
    wait_for(1'b0, 300, n);
    check("first_strobe_d3", n, 4);
    wait_for(1'b0, 300, n);
    check("strobe_period_d3", n, 4);
    @(negedge clk);
    check("strobe_width", strobe, 0);

    // divider=0: strobe every clk, period_end every 256
    divider = 8'd0;
    wait_for(1'b1, 3000, n);
    check("pe_seen_d0", period_end, 1);
    n = 0; cnt = 0;
    do begin
      @(negedge clk);
      n++;
      cnt += int'(strobe);
    end while (!period_end && n < 1000);
    check("pe_period_d0", n, 256);
    check("strobes_per_period", cnt, 256);
    @(negedge clk);

    // slew up
    mode = 2'd1; target = 8'd200; step = 8'd64;
    exp_q.push_back(8'd64); exp_q.push_back(8'd128);
    exp_q.push_back(8'd192); exp_q.push_back(8'd200);
    for (int i = 0; i < 4; i++) begin
      boundary("slew_up");
      check("slew_busy", busy, (i < 3) ? 1 : 0);
      if (i == 0) begin
        repeat (100) @(negedge clk);
        check("slew_hold_mid", level, 64);
      end
    end

    // slew down / up without wrap
    mode = 2'd0; target = 8'd10;
    exp_q.push_back(8'd10);
    boundary("direct_10");
    mode = 2'd1; target = 8'd0; step = 8'd64;
    exp_q.push_back(8'd0);
    boundary("slew_no_underflow");
    check("slew_down_busy", busy, 0);
    target = 8'd255; step = 8'd255;
    exp_q.push_back(8'd255);
    boundary("slew_no_overflow");

    // breathe
    mode = 2'd0; target = 8'd0;
    exp_q.push_back(8'd0);
    boundary("direct_0");
    mode = 2'd2; target = 8'd100; step = 8'd40;
    exp_q.push_back(8'd40); exp_q.push_back(8'd80); exp_q.push_back(8'd100);
    exp_q.push_back(8'd60); exp_q.push_back(8'd20); exp_q.push_back(8'd0);
    exp_q.push_back(8'd40);
    for (int i = 0; i < 7; i++) boundary("breathe");
    mode = 2'd3;
    exp_q.push_back(8'd40); exp_q.push_back(8'd40);
    boundary("hold_freeze");
    boundary("hold_freeze");

    // async reset mid-slew
    mode = 2'd1; target = 8'd200; step = 8'd64;
    exp_q.push_back(8'd104);
    boundary("slew_pre_reset");
    divider = 8'd3;
    repeat (20) @(negedge clk);
    wait_for(1'b0, 300, n);
    check("strobe_before_reset", strobe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_strobe", strobe, 0);
    check("async_period_end", period_end, 0);
    check("async_level", level, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_for(1'b0, 300, n);
    check("post_reset_strobe", n, 4);
    divider = 8'd0;

    // enable freeze
    mode = 2'd0; target = 8'd50;
    exp_q.push_back(8'd50);
    boundary("direct_50");
    mode = 2'd3;
    repeat (127) @(negedge clk);
    enable = 1'b0;
    mode = 2'd0; target = 8'd99;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      seen = seen | strobe | period_end;
    end
    check("freeze_strobe", seen, 0);
    check("freeze_level", level, 50);
    @(negedge clk) enable = 1'b1;
    exp_q.push_back(8'd99);
    wait_for(1'b1, 3000, n);
    check("reenable_pe", n, 256);
    @(negedge clk);
    check("reenable_level", level, exp_q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
